// File: rtl/lfsr_decrypt.sv
// lfsr_decrypt: recovers the seed and tap pattern of a 7-bit LFSR keystream from a
// known all-space preamble, then strips the keystream from the message payload.
module lfsr_decrypt #(
  parameter int         PRE_LEN = 6,
  parameter logic [6:0] SPACE   = 7'h20
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [7:0] i_in_data,
  input  logic       i_in_last,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [7:0] o_out_data,
  output logic       o_out_last,
  output logic       o_locked,
  output logic [6:0] o_tap_found,
  output logic       o_no_match
);

  // Candidate tap patterns, index 0 in the least significant slot.
  localparam logic [8:0][6:0] TAPS = {7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A,
                                      7'h72, 7'h78, 7'h48, 7'h60};
  localparam logic [3:0] LAST_PRE = 4'(PRE_LEN - 1);

  typedef enum logic [1:0] {S_PRE, S_DEC, S_ERR} state_t;

  function automatic logic [6:0] lfsr_next(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [8:0][6:0] r_cs;
  logic [8:0]      r_alive;
  logic [6:0]      r_key;
  logic [6:0]      r_tap;
  logic            r_out_valid;
  logic [7:0]      r_out_data;
  logic            r_out_last;
  logic            r_locked;
  logic            r_no_match;

  logic [6:0]      w_c;
  logic [6:0]      w_p;
  logic            w_accept;
  logic [8:0][6:0] w_cs_next;
  logic [8:0]      w_alive_new;
  logic [3:0]      w_sel_idx;
  logic            w_any;
  logic [6:0]      w_key_next;
  logic            w_unused_bit7;

  // Bit 7 of the ciphertext carries no information.
  assign w_unused_bit7 = i_in_data[7];
  assign w_c           = i_in_data[6:0];
  assign w_p           = w_c ^ SPACE;
  assign o_in_ready    = (r_state != S_DEC) || !r_out_valid || i_out_ready;
  assign w_accept      = i_in_valid && o_in_ready;
  assign w_key_next    = lfsr_next(r_key, r_tap);
  assign w_any         = |w_alive_new;

  // Each candidate advances its own state and stays alive only while it predicts the preamble.
  for (genvar gi = 0; gi < 9; gi++) begin : g_cand
    assign w_cs_next[gi]   = lfsr_next(r_cs[gi], TAPS[gi]);
    assign w_alive_new[gi] = r_alive[gi] && (w_cs_next[gi] == w_p);
  end

  // Lowest-index surviving candidate wins when several predict the preamble.
  always_comb begin
    w_sel_idx = '0;
    for (int k = 8; k >= 0; k--) begin
      if (w_alive_new[k]) w_sel_idx = 4'(k);
    end
  end

  // Message FSM: preamble tracking, payload decryption and error drain.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_PRE;
      r_cnt       <= '0;
      r_cs        <= '0;
      r_alive     <= '0;
      r_key       <= '0;
      r_tap       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_locked    <= 1'b0;
      r_no_match  <= 1'b0;
    end else begin
      if (r_out_valid && i_out_ready) r_out_valid <= 1'b0;
      case (r_state)
        S_PRE: begin
          if (w_accept) begin
            if (r_cnt == '0) begin
              r_cs       <= {9{w_p}};
              r_alive    <= '1;
              r_locked   <= 1'b0;
              r_tap      <= '0;
              r_no_match <= 1'b0;
              r_cnt      <= 4'd1;
            end else begin
              r_cs    <= w_cs_next;
              r_alive <= w_alive_new;
              r_cnt   <= r_cnt + 4'd1;
              if (r_cnt == LAST_PRE) begin
                r_cnt <= '0;
                if (w_any) begin
                  r_key    <= w_cs_next[w_sel_idx];
                  r_tap    <= TAPS[w_sel_idx];
                  r_locked <= 1'b1;
                  r_state  <= S_DEC;
                end else begin
                  r_no_match <= 1'b1;
                  r_state    <= S_ERR;
                end
              end
            end
            // A message that ends inside the preamble cannot be decoded.
            if (i_in_last) begin
              r_no_match <= 1'b1;
              r_locked   <= 1'b0;
              r_tap      <= '0;
              r_cnt      <= '0;
              r_state    <= S_PRE;
            end
          end
        end
        S_DEC: begin
          if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {1'b0, w_c ^ w_key_next};
            r_out_last  <= i_in_last;
            r_key       <= w_key_next;
            if (i_in_last) r_state <= S_PRE;
          end
        end
        S_ERR: begin
          if (w_accept && i_in_last) r_state <= S_PRE;
        end
        default: r_state <= S_PRE;
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;
  assign o_locked    = r_locked;
  assign o_tap_found = r_tap;
  assign o_no_match  = r_no_match;

endmodule

// File: tb/tb_lfsr_decrypt.sv
// Testbench for lfsr_decrypt: vector table, hand-written corner sequences and
// randomized messages checked against a brute-force decryption model.
module tb_lfsr_decrypt;

  localparam int         PRE_LEN = 6;
  localparam logic [6:0] SPACE   = 7'h20;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_in_valid = 1'b0;
  logic [7:0] i_in_data = '0;
  logic       i_in_last = 1'b0;
  logic       i_out_ready = 1'b1;
  logic       o_in_ready, o_out_valid, o_out_last, o_locked, o_no_match;
  logic [7:0] o_out_data;
  logic [6:0] o_tap_found;

  lfsr_decrypt #(.PRE_LEN(PRE_LEN), .SPACE(SPACE)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data), .i_in_last(i_in_last),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data), .o_out_last(o_out_last),
    .o_locked(o_locked), .o_tap_found(o_tap_found), .o_no_match(o_no_match)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int bp_mode = 0;  // 0: sink ready, 1: sink stalled, 2: random backpressure

  typedef struct packed {logic [7:0] d; logic l;} out_t;
  out_t exp_q[$];

  typedef struct {
    logic [7:0] c; logic last;
    logic e_lock; logic [6:0] e_tap; logic e_nm;
    logic has_out; logic [7:0] e_out;
  } vec_t;
  vec_t vecs[$];

  int taps[9] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  // Sink backpressure generator; the only driver of i_out_ready.
  always @(negedge i_clk) begin
    case (bp_mode)
      0: i_out_ready = 1'b1;
      1: i_out_ready = 1'b0;
      default: i_out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Output monitor: checks every sink handshake against the expected queue and hold stability.
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;
  always @(negedge i_clk) begin
    out_t e;
    #1;
    if (i_reset_n) begin
      if (stall_prev) begin
        chk("hold_valid", o_out_valid, 1);
        chk("hold_data", o_out_data, stall_data);
      end
      if (o_out_valid && i_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", o_out_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("out byte %02h last %0d (expect %02h last %0d)", o_out_data, o_out_last, e.d, e.l);
          chk("out_data", o_out_data, e.d);
          chk("out_last", o_out_last, e.l);
        end
      end
      stall_prev = o_out_valid && !i_out_ready;
      stall_data = o_out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Offer one byte and return #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int  n;
    logic rdy;
    @(negedge i_clk);
    i_in_valid = 1'b1; i_in_data = d; i_in_last = l;
    n = 0;
    forever begin
      #1; rdy = o_in_ready;
      @(posedge i_clk);
      if (rdy) break;
      n++;
      if (n > 300) begin
        chk("send_timeout", 0, 1);
        break;
      end
      @(negedge i_clk);
    end
    #1;
  endtask

  task automatic idle();
    @(negedge i_clk);
    i_in_valid = 1'b0; i_in_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge i_clk);
      n++;
    end
    repeat (2) @(posedge i_clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  function automatic vec_t mkv(input logic [7:0] c, input logic last, input logic lk,
                               input logic [6:0] tp, input logic nm,
                               input logic ho, input logic [7:0] eo);
    vec_t v;
    v.c = c; v.last = last; v.e_lock = lk; v.e_tap = tp; v.e_nm = nm; v.has_out = ho; v.e_out = eo;
    return v;
  endfunction

  task automatic add_good();
    vecs.push_back(mkv(8'h21, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h22, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h24, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h28, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h30, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h00, 0, 1, 7'h60, 0, 0, 0));
    vecs.push_back(mkv(8'h09, 1, 1, 7'h60, 0, 1, 8'h48));
  endtask

  task automatic send_good_pre();
    logic [7:0] pre[6] = '{8'h21, 8'h22, 8'h24, 8'h28, 8'h30, 8'h00};
    for (int i = 0; i < 6; i++) send_byte(pre[i], 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cbuf[26];
    logic [6:0] pbuf[26];
    logic [6:0] s, seed;
    int sel, n;
    logic ok, rdy;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_data", o_out_data, 0);
    chk("rst_out_last", o_out_last, 0);
    chk("rst_locked", o_locked, 0);
    chk("rst_tap", o_tap_found, 0);
    chk("rst_no_match", o_no_match, 0);
    chk("rst_in_ready", o_in_ready, 1);
    @(negedge i_clk) i_reset_n = 1'b1;

    // Vector table: good, corrupt preamble, good, 4-byte, good, exactly PRE_LEN bytes, good
    add_good();
    vecs.push_back(mkv(8'h21, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h22, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h24, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h29, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h30, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h00, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(8'h09, 1, 0, 0, 1, 0, 0));
    add_good();
    vecs.push_back(mkv(8'h21, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h22, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h24, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h28, 1, 0, 0, 1, 0, 0));
    add_good();
    vecs.push_back(mkv(8'h21, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h22, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h24, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h28, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h30, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(8'h00, 1, 0, 0, 1, 0, 0));
    add_good();
    foreach (vecs[i]) begin
      if (vecs[i].has_out) exp_q.push_back({vecs[i].e_out, vecs[i].last});
      send_byte(vecs[i].c, vecs[i].last);
      $display("vec %0d: in %02h last %0d -> locked %0d tap %02h no_match %0d",
               i, vecs[i].c, vecs[i].last, o_locked, o_tap_found, o_no_match);
      chk("vec_locked", o_locked, vecs[i].e_lock);
      chk("vec_tap", o_tap_found, vecs[i].e_tap);
      chk("vec_no_match", o_no_match, vecs[i].e_nm);
    end
    idle();
    drain();

    // Sink stall: payload 09 (-> 48) held while the next payload byte waits
    send_good_pre();
    bp_mode = 1;
    exp_q.push_back({8'h48, 1'b0});
    exp_q.push_back({8'h69, 1'b1});
    send_byte(8'h09, 1'b0);
    @(negedge i_clk);
    i_in_valid = 1'b1; i_in_data = 8'h6A; i_in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      $display("stall cycle %0d: out_valid %0d data %02h in_ready %0d", i, o_out_valid, o_out_data, o_in_ready);
      chk("stall_valid", o_out_valid, 1);
      chk("stall_data", o_out_data, 8'h48);
      chk("stall_in_ready", o_in_ready, 0);
      @(negedge i_clk);
    end
    #2 bp_mode = 0;
    n = 0;
    forever begin
      @(negedge i_clk);
      #1; rdy = o_in_ready;
      @(posedge i_clk);
      if (rdy) break;
      n++;
      if (n > 50) begin chk("stall_release_timeout", 0, 1); break; end
    end
    idle();
    drain();

    // Reset in the middle of the payload drops the pending byte
    send_good_pre();
    send_byte(8'h09, 1'b0);
    @(negedge i_clk);
    i_in_valid = 1'b0; i_in_last = 1'b0; i_reset_n = 1'b0;
    @(posedge i_clk);
    #1;
    $display("mid reset: out_valid %0d data %02h locked %0d tap %02h", o_out_valid, o_out_data, o_locked, o_tap_found);
    chk("mrst_out_valid", o_out_valid, 0);
    chk("mrst_out_data", o_out_data, 0);
    chk("mrst_out_last", o_out_last, 0);
    chk("mrst_locked", o_locked, 0);
    chk("mrst_tap", o_tap_found, 0);
    chk("mrst_no_match", o_no_match, 0);
    @(negedge i_clk) i_reset_n = 1'b1;
    exp_q.push_back({8'h48, 1'b1});
    send_good_pre();
    send_byte(8'h09, 1'b1);
    chk("post_rst_locked", o_locked, 1);
    idle();
    drain();

    // Randomized messages, one per true tap, back to back under random backpressure
    bp_mode = 2;
    for (int t = 0; t < 9; t++) begin
      seed = 7'($urandom_range(1, 127));
      s = seed;
      for (int i = 0; i < 26; i++) begin
        pbuf[i] = (i < PRE_LEN) ? SPACE : 7'($urandom_range(0, 127));
        cbuf[i] = {1'($urandom_range(0, 1)), pbuf[i] ^ s};
        s = step(s, 7'(taps[t]));
      end
      // Reference: first candidate whose keystream reproduces the whole preamble
      sel = -1;
      for (int k = 0; k < 9 && sel < 0; k++) begin
        s = cbuf[0][6:0] ^ SPACE;
        ok = 1'b1;
        for (int i = 1; i < PRE_LEN; i++) begin
          s = step(s, 7'(taps[k]));
          if (s != (cbuf[i][6:0] ^ SPACE)) ok = 1'b0;
        end
        if (ok) sel = k;
      end
      if (sel < 0) sel = t;
      s = cbuf[0][6:0] ^ SPACE;
      for (int i = 1; i < 26; i++) begin
        s = step(s, 7'(taps[sel]));
        if (i >= PRE_LEN) exp_q.push_back({1'b0, cbuf[i][6:0] ^ s, (i == 25)});
      end
      $display("rand msg tap %02h seed %02h: expect tap_found %02h", taps[t], seed, taps[sel]);
      for (int i = 0; i < 26; i++) begin
        send_byte(cbuf[i], (i == 25));
        if (i == PRE_LEN - 1) begin
          chk("rand_locked", o_locked, 1);
          chk("rand_tap", o_tap_found, taps[sel]);
          chk("rand_no_match", o_no_match, 0);
        end
      end
    end
    idle();
    drain();
    bp_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_decrypt.md
# lfsr_decrypt

Streaming decryptor for LFSR-encrypted messages: the receive-side counterpart of the 7-bit keystream LFSR used for encryption. Each message begins with a known preamble of space characters. The block uses that preamble to recover the seed and identify the tap pattern from a fixed candidate set, then strips the keystream from the remaining bytes. It sits between the ciphertext byte source and the plaintext sink, with valid/ready handshakes on both sides.

## Interface
- PRE_LEN, 6: preamble length in bytes; legal range 2..15.
- SPACE, 7'h20: plaintext value of every preamble byte.
- Clk  in  1  clock; all state changes on posedge Clk.
- Reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  ciphertext byte available.
- in_ready  out  1  block accepts the byte this cycle.
- in_data  in  8  ciphertext byte; bit 7 is ignored.
- in_last  in  1  marks the final byte of a message.
- out_valid  out  1  plaintext byte held on out_data.
- out_ready  in  1  sink accepts the byte.
- out_data  out  8  plaintext byte, {1'b0, 7-bit plaintext}.
- out_last  out  1  final plaintext byte of the message.
- locked  out  1  tap pattern identified for the current message.
- tap_found  out  7  identified tap pattern; valid while locked=1.
- no_match  out  1  preamble failed: no candidate matched, or the message was shorter than PRE_LEN.

## Operation
- Keystream step: next(s,t) = {s[5:0], ^(s & t)}.
- Encryption model: c[i][6:0] = p[i] ^ st[i], with st[0] = seed and st[i+1] = next(st[i], tap).
- Candidate taps, index 0..8: 60, 48, 78, 72, 6A, 69, 5C, 7E, 7B (hex). Each candidate has its own state register cs[k] and alive[k] flag.
- An input byte is accepted on a cycle where in_valid && in_ready.
- States:
  - PRE (reset state)
  - DEC
  - ERR
- PRE, byte 0:
  - Every cs[k] <= c[6:0] ^ SPACE; every alive[k] <= 1.
  - Clear locked, tap_found and no_match.
  - Byte counter <= 1.
- PRE, byte i in 1..PRE_LEN-1:
  - alive[k] <= alive[k] && ((c[6:0]^SPACE) == next(cs[k], tap_k)).
  - cs[k] <= next(cs[k], tap_k).
- Preamble bytes produce no output.
- After byte PRE_LEN-1:
  - If any candidate survives, using the updated flags, pick the lowest surviving index k. Then key <= next(cs[k], tap_k), tap_found <= tap_k, locked <= 1, and go to DEC.
  - If no candidate survives: no_match <= 1, go to ERR.
- in_last on a preamble byte: set no_match <= 1, stay in PRE, and reset the counter. This covers a short message and also a message of exactly PRE_LEN bytes.
- DEC, per accepted byte:
  - out_data <= {1'b0, c[6:0] ^ next(key, tap)}; key <= next(key, tap).
  - out_last <= in_last.
  - After accepting the in_last byte, return to PRE.
- ERR: accept and discard bytes; after accepting the in_last byte, return to PRE. no_match holds until byte 0 of the next message.
- Bit 7 of in_data is never used.

## Timing
- Reset (Reset_n=0 at posedge) values:
  - state PRE, counter 0.
  - out_valid, out_last, out_data, locked, tap_found, no_match all 0.
  - alive[] 0, cs[] 0, key 0.
- in_ready:
  - 1 in PRE and ERR.
  - In DEC, !out_valid || out_ready, so a full-throughput stream passes while the sink is ready.
- Output latency: the byte accepted at edge N appears with out_valid=1 after edge N.
- out_valid and out_data stay stable until out_ready=1.
- locked and tap_found update on the edge that accepts the last preamble byte. The first DEC byte can be accepted on the next cycle.
- Reset mid-message: the partial message is abandoned, and any pending output byte is dropped.
- Back-to-back messages: byte 0 of the next message may be accepted on the cycle right after in_last is accepted, even while the final out byte is still pending.

## Test plan
- Seed 01, tap 60, PRE_LEN 6:
  - Send ciphertext 21 22 24 28 30 00 09(last).
  - Required: locked=1 and tap_found=60 after byte 6.
  - Single output 48 with out_last=1.
- Same stream with out_ready held 0 for 5 cycles after out_valid rises.
  - Required: out_data stays 48, in_ready=0 until the handshake completes.
- Corrupt preamble byte 3 to 29.
  - Required: no_match=1, no out_valid, all bytes consumed.
  - A correct message sent next decodes normally and clears no_match on its byte 0.
- Message of 4 bytes with in_last on byte 3.
  - Required: no_match=1, state PRE, no output.
- Assert Reset_n=0 for one cycle in the middle of the DEC payload.
  - Required: all outputs 0 and out_valid=0 on the next cycle.
  - The fresh message that follows decodes correctly.
- Randomized: for each of the 9 taps, random seed ≠ 0 and a 20-byte payload, checked against a reference model.
  - Where several candidates survive the preamble, tap_found must equal the lowest surviving index.
